vproc_mem_arbiter: RTL
======================

# vproc_mem_arbiter

Shares the single 32-bit memory port of `vproc_top` between `NUM_REQ` requesters, for example the instruction fetch and the vector/scalar data ports. Each cycle it grants at most one requester onto the memory port. It records the granted requester's index in an in-order ID FIFO and routes each returning response back to the requester that issued it. The memory side matches the testbench memory protocol: no back-pressure, and exactly one response per accepted request after a fixed but arbitrary latency.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (≥2).
- `MAX_OUTST`, default 4: maximum accepted-but-unanswered requests (≥1). Must cover memory latency for full throughput.

Ports (each `NUM_REQ`-wide port holds one lane per requester):
- `clk_i` in 1: clock. Everything is synchronous to its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in NUM_REQ: request valid per requester.
- `req_addr_i` in NUM_REQ×32: address per requester.
- `req_we_i` in NUM_REQ: write enable per requester.
- `req_be_i` in NUM_REQ×4: byte enables per requester.
- `req_wdata_i` in NUM_REQ×32: write data per requester.
- `gnt_o` out NUM_REQ: one-hot grant. A request is accepted when `req_i[k] & gnt_o[k]`.
- `rvalid_o` out NUM_REQ: response valid, one-hot.
- `err_o` out NUM_REQ: response error, qualified by `rvalid_o`.
- `rdata_o` out 32: response data, broadcast to all requesters.
- `mem_req_o` out 1: memory request.
- `mem_addr_o` out 32: memory address.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out 4: memory byte enables.
- `mem_wdata_o` out 32: memory write data.
- `mem_rvalid_i` in 1: memory response valid. Asserted for reads and writes alike.
- `mem_err_i` in 1: memory response error.
- `mem_rdata_i` in 32: memory response data.
- `orphan_o` out 1: sticky flag. Set when `mem_rvalid_i` arrives while the ID FIFO is empty. Cleared only by reset.

## Operation
- Requester contract: `req_i[k]` and its address/we/be/wdata stay stable until granted. The arbiter never grants a deasserted request.
- Stall condition: the ID FIFO is full and `mem_rvalid_i` is low in the same cycle.
- When stalled, `gnt_o` = 0 and `mem_req_o` = 0.
- When the FIFO is full and `mem_rvalid_i` is high in the same cycle, a grant is still allowed: the dequeue and enqueue happen together and the count is unchanged.
- When not stalled and any `req_i` is set:
  - exactly one `gnt_o` bit is set, chosen by the arbitration policy (see Configuration);
  - `mem_req_o` = 1 and the `mem_*` fields are muxed from the winner;
  - the winner's index, `$clog2(NUM_REQ)` bits wide, is pushed into the ID FIFO.
- When no request is set, `mem_req_o` = 0 and the `mem_*` data outputs are driven to 0.
- Response routing: when `mem_rvalid_i` is high, the FIFO head index `h` is popped and `rvalid_o[h]` = 1.
  - `err_o[h]` = `mem_err_i`.
  - `rdata_o` = `mem_rdata_i`.
  - All other `rvalid_o`/`err_o` bits are 0.
- Orphan response (FIFO empty while `mem_rvalid_i` is high): `rvalid_o` = 0, nothing is popped, `orphan_o` is set the next cycle.
- Occupancy counter: `$clog2(MAX_OUTST+1)` bits. It increments on grant-only, decrements on response-only, and is unchanged on both or neither. FIFO read and write pointers wrap modulo `MAX_OUTST`.
- Reset mid-operation: the FIFO and counter are flushed and the arbitration pointer returns to 0. Responses to flushed requests that arrive after reset count as orphans. The owner of `rst_i` must reset the memory pipeline at the same time.

## Timing
- Grant and memory request are combinational from `req_i` and state, in the same cycle. The arbiter adds zero cycles of request latency.
- The response path is combinational from `mem_rvalid_i`/`mem_err_i`/`mem_rdata_i`, adding zero cycles of response latency.
- Throughput is one request per cycle while `MAX_OUTST` ≥ memory latency + 1.
- Reset values: FIFO empty, count 0, pointer 0, `orphan_o` 0. With `req_i` = 0 and `mem_rvalid_i` = 0, all outputs are 0.
- State updates only on the `clk_i` rising edge. Reset has priority over all updates.

## Configuration
- `VPROC_MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A `$clog2(NUM_REQ)`-bit pointer marks the highest-priority index.
  - Search order is pointer, pointer+1, … modulo `NUM_REQ`.
  - After each grant the pointer moves to winner+1 modulo `NUM_REQ`.
  - The pointer is unchanged when nothing is granted.
- Undefined: fixed priority, with index 0 highest. There is no pointer register.

## Structure
- `vproc_pkg` holds the request struct typedef `mem_req_t` {addr, we, be, wdata} and the response struct typedef `mem_rsp_t` {err, rdata}. The top-level ports stay flat.
- Sub-module `vproc_mem_arb_fifo`: a synchronous ID FIFO parameterized by depth and width, with `full`, `empty`, push, pop and head outputs, and support for push and pop in the same cycle.

## Test plan
- Reset, then `req_i`=2'b01, addr `0x100`, read; memory latency 1 → same cycle `gnt_o`=01 and `mem_addr_o`=`0x100`; next cycle `rvalid_o`=01 with `mem_rdata_i` passed through.
- Both requesters hold `req_i`=2'b11 continuously, `RR_EN` set → grants alternate 01,10,01,…; with the macro undefined → 01 every cycle.
- `MAX_OUTST`=2, memory latency 4, `req_i`=01 held → two grants, then stall until the first response; in the response cycle a new grant occurs and the count stays 2.
- Interleaved grants 01,10,01 with `mem_err_i`=1 on the second response → responses go to 01, 10 (with `err_o`=10), 01, in order.
- `mem_rvalid_i`=1 with the FIFO empty → `rvalid_o`=00 and `orphan_o`=1 from the next cycle until `rst_i`.
- `rst_i` asserted with 3 requests outstanding → FIFO empty afterwards; the following `mem_rvalid_i` sets `orphan_o`, and the next grant's response routes correctly.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared types for the vproc memory arbiter: request and response bundles.
package vproc_pkg;

   localparam int unsigned MemAddrW = 32;
   localparam int unsigned MemDataW = 32;
   localparam int unsigned MemBeW   = 4;

   typedef struct packed {
      logic [MemAddrW-1:0] addr;
      logic                we;
      logic [MemBeW-1:0]   be;
      logic [MemDataW-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic                err;
      logic [MemDataW-1:0] rdata;
   } mem_rsp_t;

endpackage

// File: rtl/vproc_mem_arb_fifo.sv
// In-order ID FIFO for the memory arbiter. Push and pop may happen in the same cycle,
// including when full (the pop frees the slot the push fills).
module vproc_mem_arb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Status flags and effective push/pop qualification
   always_comb begin
      full_o  = (cnt_q == CntW'(DEPTH));
      empty_o = (cnt_q == '0);
      head_o  = mem_q[rptr_q];
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
   end

   // Storage: data needs no reset, only the pointers define validity
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= next_ptr(wptr_q);
         if (do_pop)  rptr_q <= next_ptr(rptr_q);
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (!do_push && do_pop) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/vproc_mem_arbiter.sv
// Shares one memory port between NUM_REQ requesters and routes responses back in order.
// Define VPROC_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority
// with requester 0 highest.
module vproc_mem_arbiter
   import vproc_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [NUM_REQ*32-1:0] req_addr_i,
   input  logic [NUM_REQ-1:0]    req_we_i,
   input  logic [NUM_REQ*4-1:0]  req_be_i,
   input  logic [NUM_REQ*32-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]    gnt_o,
   output logic [NUM_REQ-1:0]    rvalid_o,
   output logic [NUM_REQ-1:0]    err_o,
   output logic [31:0]           rdata_o,
   output logic                  mem_req_o,
   output logic [31:0]           mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic                  mem_err_i,
   input  logic [31:0]           mem_rdata_i,
   output logic                  orphan_o
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   mem_req_t        reqs [NUM_REQ];
   mem_req_t        sel;
   mem_rsp_t        rsp;
   logic [IdxW-1:0] win;
   logic [IdxW-1:0] fifo_head;
   logic            fifo_full, fifo_empty;
   logic            stall, grant, pop;
   logic            orphan_q;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign reqs[k] = '{addr:  req_addr_i[32*k +: 32],
                         we:    req_we_i[k],
                         be:    req_be_i[4*k +: 4],
                         wdata: req_wdata_i[32*k +: 32]};
   end

`ifdef VPROC_MEM_ARB_RR_EN
   logic [IdxW-1:0] ptr_q;

   // Round-robin winner: first requester at or after the pointer
   always_comb begin
      int unsigned cand;
      logic        found;
      cand  = 0;
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req_i[IdxW'(cand)]) begin
            found = 1'b1;
            win   = IdxW'(cand);
         end
      end
   end

   // Pointer moves past the winner on every grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (grant) begin
         ptr_q <= (win == IdxW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
   end
`else
   // Fixed-priority winner: lowest requesting index
   always_comb begin
      win = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_i[IdxW'(i)]) win = IdxW'(i);
      end
   end
`endif

   // Grant and request mux; a response in the same cycle frees a full FIFO slot
   always_comb begin
      stall       = fifo_full & ~mem_rvalid_i;
      grant       = (|req_i) & ~stall;
      sel         = reqs[win];
      gnt_o       = '0;
      if (grant) gnt_o[win] = 1'b1;
      mem_req_o   = grant;
      mem_addr_o  = grant ? sel.addr  : '0;
      mem_we_o    = grant ? sel.we    : 1'b0;
      mem_be_o    = grant ? sel.be    : '0;
      mem_wdata_o = grant ? sel.wdata : '0;
   end

   // Response routing to the requester at the FIFO head
   always_comb begin
      rsp      = '{err: mem_err_i, rdata: mem_rdata_i};
      pop      = mem_rvalid_i & ~fifo_empty;
      rvalid_o = '0;
      err_o    = '0;
      if (pop) begin
         rvalid_o[fifo_head] = 1'b1;
         err_o[fifo_head]    = rsp.err;
      end
      rdata_o  = mem_rvalid_i ? rsp.rdata : '0;
   end

   // Sticky flag for responses with nothing outstanding
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         orphan_q <= 1'b0;
      end else if (mem_rvalid_i && fifo_empty) begin
         orphan_q <= 1'b1;
      end
   end

   assign orphan_o = orphan_q;

   vproc_mem_arb_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (IdxW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (grant),
      .pop_i   (pop),
      .wdata_i (win),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule
